// File: rtl/quad_coef_unpack.sv
// Serial a,b,c coefficient stream to three parallel AXI-Stream masters that present
// each triple together, with framing check and error/triple counters.
module quad_coef_unpack #(
  parameter int unsigned SIZE  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic [SIZE-1:0]  s_axis_coef_tdata,
  input  logic             s_axis_coef_tvalid,
  output logic             s_axis_coef_tready,
  input  logic             s_axis_coef_tlast,
  output logic [SIZE-1:0]  m_axis_a_tdata,
  output logic             m_axis_a_tvalid,
  input  logic             m_axis_a_tready,
  output logic [SIZE-1:0]  m_axis_b_tdata,
  output logic             m_axis_b_tvalid,
  input  logic             m_axis_b_tready,
  output logic [SIZE-1:0]  m_axis_c_tdata,
  output logic             m_axis_c_tvalid,
  input  logic             m_axis_c_tready,
  output logic [CNT_W-1:0] frame_err_count,
  output logic [CNT_W-1:0] triple_count
);

  localparam logic [1:0] IdxA = 2'd0;
  localparam logic [1:0] IdxB = 2'd1;
  localparam logic [1:0] IdxC = 2'd2;

  logic [1:0]       idx_q, idx_d;
  logic [SIZE-1:0]  sa_q, sa_d, sb_q, sb_d;
  logic [SIZE-1:0]  oa_q, oa_d, ob_q, ob_d, oc_q, oc_d;
  logic             pa_q, pa_d, pb_q, pb_d, pc_q, pc_d;
  logic [CNT_W-1:0] fe_q, fe_d, tc_q, tc_d;

  logic at_c, slot_free, accept, load, frame_err;
  logic pa_rem, pb_rem, pc_rem;

  // A flag survives the edge only if its channel is not being handshaken.
  assign pa_rem    = pa_q & ~m_axis_a_tready;
  assign pb_rem    = pb_q & ~m_axis_b_tready;
  assign pc_rem    = pc_q & ~m_axis_c_tready;
  assign slot_free = ~(pa_rem | pb_rem | pc_rem);
  assign at_c      = (idx_q == IdxC);

  assign s_axis_coef_tready = aresetn & (~at_c | slot_free);
  assign accept    = s_axis_coef_tvalid & s_axis_coef_tready;
  assign load      = accept & at_c;
  assign frame_err = accept & (at_c ? ~s_axis_coef_tlast : s_axis_coef_tlast);

  always_comb begin
    idx_d = idx_q;
    sa_d  = sa_q;
    sb_d  = sb_q;
    oa_d  = oa_q;
    ob_d  = ob_q;
    oc_d  = oc_q;
    pa_d  = pa_rem;
    pb_d  = pb_rem;
    pc_d  = pc_rem;
    fe_d  = fe_q;
    tc_d  = tc_q;

    if (accept) begin
      if (at_c || s_axis_coef_tlast) idx_d = IdxA;
      else                           idx_d = idx_q + 2'd1;
      if (idx_q == IdxA) sa_d = s_axis_coef_tdata;
      if (idx_q == IdxB) sb_d = s_axis_coef_tdata;
    end

    if (load) begin
      oa_d = sa_q;
      ob_d = sb_q;
      oc_d = s_axis_coef_tdata;
      pa_d = 1'b1;
      pb_d = 1'b1;
      pc_d = 1'b1;
    end

    if (frame_err && (fe_q != {CNT_W{1'b1}})) fe_d = fe_q + CNT_W'(1);

    // Count the triple on the edge its last outstanding channel retires.
    if ((pa_q | pb_q | pc_q) && slot_free) tc_d = tc_q + CNT_W'(1);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      idx_q <= IdxA;
      sa_q  <= '0;
      sb_q  <= '0;
      oa_q  <= '0;
      ob_q  <= '0;
      oc_q  <= '0;
      pa_q  <= 1'b0;
      pb_q  <= 1'b0;
      pc_q  <= 1'b0;
      fe_q  <= '0;
      tc_q  <= '0;
    end else begin
      idx_q <= idx_d;
      sa_q  <= sa_d;
      sb_q  <= sb_d;
      oa_q  <= oa_d;
      ob_q  <= ob_d;
      oc_q  <= oc_d;
      pa_q  <= pa_d;
      pb_q  <= pb_d;
      pc_q  <= pc_d;
      fe_q  <= fe_d;
      tc_q  <= tc_d;
    end
  end

  assign m_axis_a_tdata  = oa_q;
  assign m_axis_b_tdata  = ob_q;
  assign m_axis_c_tdata  = oc_q;
  assign m_axis_a_tvalid = pa_q;
  assign m_axis_b_tvalid = pb_q;
  assign m_axis_c_tvalid = pc_q;
  assign frame_err_count = fe_q;
  assign triple_count    = tc_q;

endmodule

// File: tb/tb_quad_coef_unpack.sv
// Directed, table-driven bench for quad_coef_unpack (CNT_W=8 to reach saturation quickly).
module tb_quad_coef_unpack;

  localparam int unsigned SIZE  = 32;
  localparam int unsigned CNT_W = 8;

  logic             aclk = 1'b0;
  logic             aresetn = 1'b0;
  logic [SIZE-1:0]  s_tdata = '0;
  logic             s_tvalid = 1'b0;
  logic             s_tready;
  logic             s_tlast = 1'b0;
  logic [SIZE-1:0]  a_tdata, b_tdata, c_tdata;
  logic             a_tvalid, b_tvalid, c_tvalid;
  logic             a_tready = 1'b1, b_tready = 1'b1, c_tready = 1'b1;
  logic [CNT_W-1:0] frame_err_count, triple_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 aclk = ~aclk;

  quad_coef_unpack #(.SIZE(SIZE), .CNT_W(CNT_W)) dut (
    .aclk               (aclk),
    .aresetn            (aresetn),
    .s_axis_coef_tdata  (s_tdata),
    .s_axis_coef_tvalid (s_tvalid),
    .s_axis_coef_tready (s_tready),
    .s_axis_coef_tlast  (s_tlast),
    .m_axis_a_tdata     (a_tdata),
    .m_axis_a_tvalid    (a_tvalid),
    .m_axis_a_tready    (a_tready),
    .m_axis_b_tdata     (b_tdata),
    .m_axis_b_tvalid    (b_tvalid),
    .m_axis_b_tready    (b_tready),
    .m_axis_c_tdata     (c_tdata),
    .m_axis_c_tvalid    (c_tvalid),
    .m_axis_c_tready    (c_tready),
    .frame_err_count    (frame_err_count),
    .triple_count       (triple_count)
  );

  typedef struct {
    logic        vld;
    logic [31:0] d;
    logic        last;
    logic        ra, rb, rc;
    logic        rdy;          // expected s_tready before the edge
    logic        va, vb, vc;   // expected valids after the edge
    logic [31:0] ea, eb, ec;   // expected data, checked where valid
    int          tc, fe;       // expected counters after the edge
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic vld, input logic [31:0] d, input logic last,
                     input logic ra, input logic rb, input logic rc, input logic rdy,
                     input logic va, input logic vb, input logic vc,
                     input logic [31:0] ea, input logic [31:0] eb, input logic [31:0] ec,
                     input int tc, input int fe);
    vec_t v;
    v.vld = vld; v.d = d; v.last = last; v.ra = ra; v.rb = rb; v.rc = rc; v.rdy = rdy;
    v.va = va; v.vb = vb; v.vc = vc; v.ea = ea; v.eb = eb; v.ec = ec; v.tc = tc; v.fe = fe;
    vt.push_back(v);
  endtask

  task automatic apply(input vec_t v, input int n);
    @(negedge aclk);
    s_tvalid = v.vld; s_tdata = v.d; s_tlast = v.last;
    a_tready = v.ra; b_tready = v.rb; c_tready = v.rc;
    #1;
    chk($sformatf("v%0d s_tready", n), 32'(s_tready), 32'(v.rdy));
    @(posedge aclk);
    #1;
    chk($sformatf("v%0d a_tvalid", n), 32'(a_tvalid), 32'(v.va));
    chk($sformatf("v%0d b_tvalid", n), 32'(b_tvalid), 32'(v.vb));
    chk($sformatf("v%0d c_tvalid", n), 32'(c_tvalid), 32'(v.vc));
    if (v.va) chk($sformatf("v%0d a_tdata", n), a_tdata, v.ea);
    if (v.vb) chk($sformatf("v%0d b_tdata", n), b_tdata, v.eb);
    if (v.vc) chk($sformatf("v%0d c_tdata", n), c_tdata, v.ec);
    chk($sformatf("v%0d triple_count", n), 32'(triple_count), 32'(v.tc));
    chk($sformatf("v%0d frame_err_count", n), 32'(frame_err_count), 32'(v.fe));
  endtask

  task automatic apply_one(input logic vld, input logic [31:0] d, input logic last,
                           input logic ra, input logic rb, input logic rc, input logic rdy,
                           input logic va, input logic vb, input logic vc,
                           input logic [31:0] ea, input logic [31:0] eb, input logic [31:0] ec,
                           input int tc, input int fe, input int n);
    vt.delete();
    add(vld, d, last, ra, rb, rc, rdy, va, vb, vc, ea, eb, ec, tc, fe);
    apply(vt[0], n);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " a_tvalid"}, 32'(a_tvalid), 32'd0);
    chk({tag, " b_tvalid"}, 32'(b_tvalid), 32'd0);
    chk({tag, " c_tvalid"}, 32'(c_tvalid), 32'd0);
    chk({tag, " a_tdata"}, a_tdata, 32'd0);
    chk({tag, " s_tready"}, 32'(s_tready), 32'd0);
    chk({tag, " triple_count"}, 32'(triple_count), 32'd0);
    chk({tag, " frame_err_count"}, 32'(frame_err_count), 32'd0);
  endtask

  initial begin
    #2;
    chk_reset_state("reset");
    @(negedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;

    // Single triple, exactly one valid cycle.
    add(1, 32'h3F800000, 0, 1,1,1, 1, 0,0,0, 0,0,0, 0,0);
    add(1, 32'hC0000000, 0, 1,1,1, 1, 0,0,0, 0,0,0, 0,0);
    add(1, 32'h40400000, 1, 1,1,1, 1, 1,1,1, 32'h3F800000,32'hC0000000,32'h40400000, 0,0);
    add(0, 32'h0,        0, 1,1,1, 1, 0,0,0, 0,0,0, 1,0);
    // Four continuous triples.
    for (int t = 1; t <= 4; t++) begin
      logic [31:0] base;
      base = 32'(t * 16);
      add(1, base+1, 0, 1,1,1, 1, 0,0,0, 0,0,0, t,0);
      add(1, base+2, 0, 1,1,1, 1, 0,0,0, 0,0,0, t,0);
      add(1, base+3, 1, 1,1,1, 1, 1,1,1, base+1,base+2,base+3, t,0);
    end
    add(0, 32'h0, 0, 1,1,1, 1, 0,0,0, 0,0,0, 5,0);
    // b held off: a/c retire, next c word stalls until b frees the slot.
    add(1, 32'h51, 0, 1,0,1, 1, 0,0,0, 0,0,0, 5,0);
    add(1, 32'h52, 0, 1,0,1, 1, 0,0,0, 0,0,0, 5,0);
    add(1, 32'h53, 1, 1,1,1, 1, 1,1,1, 32'h51,32'h52,32'h53, 5,0);
    add(1, 32'h61, 0, 1,0,1, 1, 0,1,0, 0,32'h52,0, 5,0);
    add(1, 32'h62, 0, 1,0,1, 1, 0,1,0, 0,32'h52,0, 5,0);
    add(1, 32'h63, 1, 1,0,1, 0, 0,1,0, 0,32'h52,0, 5,0);
    add(1, 32'h63, 1, 1,0,1, 0, 0,1,0, 0,32'h52,0, 5,0);
    add(1, 32'h63, 1, 1,0,1, 0, 0,1,0, 0,32'h52,0, 5,0);
    add(1, 32'h63, 1, 1,1,1, 1, 1,1,1, 32'h61,32'h62,32'h63, 6,0);
    add(0, 32'h0,  0, 1,1,1, 1, 0,0,0, 0,0,0, 7,0);
    // Early tlast, then a clean 1.0/2.0/3.0.
    add(1, 32'h71,       0, 1,1,1, 1, 0,0,0, 0,0,0, 7,0);
    add(1, 32'h72,       1, 1,1,1, 1, 0,0,0, 0,0,0, 7,1);
    add(1, 32'h3F800000, 0, 1,1,1, 1, 0,0,0, 0,0,0, 7,1);
    add(1, 32'h40000000, 0, 1,1,1, 1, 0,0,0, 0,0,0, 7,1);
    add(1, 32'h40400000, 1, 1,1,1, 1, 1,1,1, 32'h3F800000,32'h40000000,32'h40400000, 7,1);
    add(0, 32'h0,        0, 1,1,1, 1, 0,0,0, 0,0,0, 8,1);
    // Missing tlast on the c word: still emitted, counted as error.
    add(1, 32'h81, 0, 1,1,1, 1, 0,0,0, 0,0,0, 8,1);
    add(1, 32'h82, 0, 1,1,1, 1, 0,0,0, 0,0,0, 8,1);
    add(1, 32'h83, 0, 1,1,1, 1, 1,1,1, 32'h81,32'h82,32'h83, 8,2);
    add(0, 32'h0,  0, 1,1,1, 1, 0,0,0, 0,0,0, 9,2);

    for (int i = 0; i < vt.size(); i++) apply(vt[i], i);

    // Saturation: 300 early-tlast words on top of the existing 2 errors.
    for (int i = 0; i < 300; i++) begin
      @(negedge aclk);
      s_tvalid = 1'b1; s_tdata = 32'(i); s_tlast = 1'b1;
      @(posedge aclk);
      #1;
      if (i == 251) chk("fe before saturation", 32'(frame_err_count), 32'd254);
      if (i == 252) chk("fe at saturation", 32'(frame_err_count), 32'd255);
    end
    chk("fe held saturated", 32'(frame_err_count), 32'd255);
    chk("tc after errors", 32'(triple_count), 32'd9);
    chk("no valid after errors", 32'(a_tvalid | b_tvalid | c_tvalid), 32'd0);

    // Reset mid-triple.
    apply_one(1, 32'hA1, 0, 1,1,1, 1, 0,0,0, 0,0,0, 9,255, 100);
    apply_one(1, 32'hA2, 0, 1,1,1, 1, 0,0,0, 0,0,0, 9,255, 101);
    @(negedge aclk);
    s_tvalid = 1'b0;
    #2 aresetn = 1'b0;
    #1 chk_reset_state("rst mid-triple");
    @(negedge aclk);
    aresetn = 1'b1;

    // Reset with a pending slot.
    apply_one(1, 32'hB1, 0, 0,0,0, 1, 0,0,0, 0,0,0, 0,0, 102);
    apply_one(1, 32'hB2, 0, 0,0,0, 1, 0,0,0, 0,0,0, 0,0, 103);
    apply_one(1, 32'hB3, 1, 0,0,0, 1, 1,1,1, 32'hB1,32'hB2,32'hB3, 0,0, 104);
    @(negedge aclk);
    s_tvalid = 1'b0;
    #2 aresetn = 1'b0;
    #1 chk_reset_state("rst pending");
    @(negedge aclk);
    aresetn = 1'b1;

    apply_one(0, 32'h0,  0, 1,1,1, 1, 0,0,0, 0,0,0, 0,0, 105);
    apply_one(1, 32'hC1, 0, 1,1,1, 1, 0,0,0, 0,0,0, 0,0, 106);
    apply_one(1, 32'hC2, 0, 1,1,1, 1, 0,0,0, 0,0,0, 0,0, 107);
    apply_one(1, 32'hC3, 1, 1,1,1, 1, 1,1,1, 32'hC1,32'hC2,32'hC3, 0,0, 108);
    apply_one(0, 32'h0,  0, 1,1,1, 1, 0,0,0, 0,0,0, 1,0, 109);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/quad_coef_unpack.md
Name: quad_coef_unpack

Overview:
Upstream feeder for the quadratic solver datapath. It accepts one serial AXI-Stream of float coefficients in a, b, c order and presents each complete triple on three parallel AXI-Stream masters. The a, b and c masters are presented together, which the solver's delay-matched side pipes require. The block also checks framing and counts framing errors and emitted triples.

Parameters:
SIZE, 32, float word width in bits (IEEE layout; data is passed through, never interpreted)
CNT_W, 16, width of the status counters

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
s_axis_coef_tdata  in  SIZE  serial coefficient word
s_axis_coef_tvalid  in  1  serial word valid
s_axis_coef_tready  out  1  serial word accepted when high with tvalid
s_axis_coef_tlast  in  1  marks the final (c) word of a triple
m_axis_a_tdata  out  SIZE  coefficient a
m_axis_a_tvalid  out  1  a valid
m_axis_a_tready  in  1  a accepted
m_axis_b_tdata  out  SIZE  coefficient b
m_axis_b_tvalid  out  1  b valid
m_axis_b_tready  in  1  b accepted
m_axis_c_tdata  out  SIZE  coefficient c
m_axis_c_tvalid  out  1  c valid
m_axis_c_tready  in  1  c accepted
frame_err_count  out  CNT_W  saturating count of framing errors
triple_count  out  CNT_W  wrapping count of fully delivered triples

Behaviour:
- Reset (aresetn low, asynchronous, any cycle): all m_*_tvalid=0; all tdata=0; idx=0; slot empty; pending flags cleared; both counters 0; s_axis_coef_tready=0 while in reset. Any partial triple or undelivered triple is discarded. No output is produced until new input arrives.
- Input index idx cycles 0 (a), 1 (b), 2 (c). Words at idx 0 and 1 go into staging registers sa and sb.
- s_axis_coef_tready:
  - 1 when idx is 0 or 1.
  - When idx is 2: 1 iff the output slot is empty or frees in this same cycle.
- Output slot: registers oa/ob/oc plus pending flags pa/pb/pc.
  - On an accepted idx 2 word: the slot loads oa=sa, ob=sb, oc=word and sets pa=pb=pc=1.
  - Load latency is 1: the word is accepted at edge N and all three tvalid are high from N+1.
- Valid outputs:
  - m_x_tvalid = px.
  - px clears on the edge where m_x_tvalid and m_x_tready are both high.
  - The three channels retire independently; tdata holds stable while px=1.
  - tvalid never depends combinationally on tready.
- Slot free: the slot "frees this cycle" when every still-set px is being handshaken this cycle.
  - Back-to-back triples are then loaded without a bubble.
  - Sustained throughput is 1 triple per 3 input cycles.
- triple_count increments (wraps) on the edge where the last pending flag clears. It increments once per triple, including when the flags clear simultaneously.
- Framing, when the accepted word has tlast=1 at idx 0 or 1:
  - The partial triple is discarded and idx returns to 0.
  - frame_err_count increments; it saturates at 2^CNT_W-1.
  - The slot is unaffected.
- Framing, when the accepted word has tlast=0 at idx 2:
  - The triple is still loaded and idx returns to 0.
  - frame_err_count increments.
- Input is stalled only at idx 2; sa and sb are never overwritten before being copied into the slot.

Test Plan:
- Reset then stream 0x3F800000, 0xC0000000, 0x40400000 (last on 3rd) with all readies=1 -> one cycle after the 3rd accept, a/b/c tvalid=1 with those values for exactly 1 cycle; triple_count=1; frame_err_count=0.
- 4 triples streamed continuously, readies=1 -> s_axis_coef_tready never low; triple_count=4; output triples are in order with no bubbles between slot loads.
- Triple loaded; m_axis_b_tready=0 for 5 cycles, a and c ready -> a_tvalid and c_tvalid drop after 1 cycle, b_tvalid stays high with stable data; the next c word sees tready=0 until b retires; the next triple's a and b words are accepted meanwhile.
- tlast on the 2nd word, then a clean triple 1.0, 2.0, 3.0 -> frame_err_count=1; emitted triple is exactly 1.0/2.0/3.0; triple_count=1.
- 3rd word without tlast -> triple emitted; frame_err_count=1; 300 consecutive early-tlast errors with CNT_W=8 -> frame_err_count holds at 255.
- aresetn pulsed low mid-triple and with a pending slot -> all tvalid=0 asynchronously, counters=0; the next clean triple is delivered correctly.
